// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus an iterative
// radix-2 shift-add multiplier that holds off issue (ready_o=0) while running.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o,
  output logic             busy_o
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_ADDI = 3'b110;
  localparam logic [2:0] OP_SRAI = 3'b111;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    MUL_BUSY
  } state_t;

  // Handshake: an op transfers on a rising edge where valid_i & ready_o are
  // both high and flush_i is low; the source holds valid_i and operands until then.
  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   cnt;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] acc_next;

  assign ready_o = (state == IDLE);
  assign busy_o  = (state == MUL_BUSY);
  assign shamt   = data2_i[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      OP_AND:  alu_res = data1_i & data2_i;
      OP_XOR:  alu_res = data1_i ^ data2_i;
      OP_SLL:  alu_res = data1_i << shamt;
      OP_ADD:  alu_res = data1_i + data2_i;
      OP_SUB:  alu_res = data1_i - data2_i;
      OP_ADDI: alu_res = data1_i + data2_i;
      OP_SRAI: alu_res = $signed(data1_i) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  assign term     = mplier[0] ? mcand : '0;
  assign acc_next = acc + term;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
      Zero_o  <= 1'b1;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i && !flush_i) begin
            if (ALUCtrl_i == OP_MUL) begin
              mcand  <= data1_i;
              mplier <= data2_i;
              acc    <= '0;
              cnt    <= '0;
              state  <= MUL_BUSY;
            end else begin
              data_o  <= alu_res;
              Zero_o  <= (alu_res == '0);
              valid_o <= 1'b1;
            end
          end
        end
        MUL_BUSY: begin
          // A flush abandons the product; data_o keeps the last real result.
          if (flush_i) begin
            state <= IDLE;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              data_o  <= acc_next;
              Zero_o  <= (acc_next == '0);
              valid_o <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed scenarios plus random ops,
// results checked by an independent monitor against an expected queue.
module tb_alu_multicycle;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_n_i = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [2:0]   ALUCtrl_i = 3'b000;
  logic [W-1:0] data1_i = '0;
  logic [W-1:0] data2_i = '0;
  logic         flush_i = 1'b0;
  logic         valid_o;
  logic [W-1:0] data_o;
  logic         Zero_o;
  logic         busy_o;

  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  alu_multicycle #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o),
    .ALUCtrl_i(ALUCtrl_i), .data1_i(data1_i), .data2_i(data2_i),
    .flush_i(flush_i), .valid_o(valid_o), .data_o(data_o),
    .Zero_o(Zero_o), .busy_o(busy_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model, written from the operation definitions
  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    int sh;
    sh = b % W;
    case (op)
      3'd0: return a & b;
      3'd1: return a ^ b;
      3'd2: return a << sh;
      3'd3: return a + b;
      3'd4: return a - b;
      3'd5: begin prod = {{W{1'b0}}, a} * {{W{1'b0}}, b}; return prod[W-1:0]; end
      3'd6: return a + b;
      default: return W'($signed(a) >>> sh);
    endcase
  endfunction

  // driver: present op at a negedge, hold until ready_o; transfer at next posedge
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit expect_result);
    int waited;
    @(negedge clk_i);
    valid_i = 1'b1; ALUCtrl_i = op; data1_i = a; data2_i = b;
    waited = 0;
    while (!ready_o && waited < 100) begin
      @(negedge clk_i);
      waited++;
    end
    if (!ready_o) begin
      check("issue_ready_timeout", 64'(ready_o), 64'd1);
      valid_i = 1'b0;
    end else if (expect_result) begin
      exp_q.push_back(model(op, a, b));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      valid_i = 1'b0;
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk_i) begin
    if (rst_n_i && valid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid_o", 64'(data_o), 64'hDEAD);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("data_o", 64'(data_o), 64'(e));
        check("Zero_o", 64'(Zero_o), 64'(e == '0));
      end
    end
  end

  logic [W-1:0] held;

  initial begin
    // reset state
    #12;
    check("rst_data_o", 64'(data_o), 64'd0);
    check("rst_Zero_o", 64'(Zero_o), 64'd1);
    check("rst_valid_o", 64'(valid_o), 64'd0);
    check("rst_busy_o", 64'(busy_o), 64'd0);
    check("rst_ready_o", 64'(ready_o), 64'd1);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // SUB 5-5: one-cycle valid pulse, zero result
    issue(3'd4, 32'd5, 32'd5, 1);
    idle(1);
    check("sub_valid_pulse", 64'(valid_o), 64'd1);
    idle(1);
    check("sub_valid_drop", 64'(valid_o), 64'd0);

    // back-to-back single-cycle ops
    issue(3'd3, 32'h7FFF_FFFF, 32'd1, 1);
    issue(3'd7, 32'h8000_0000, 32'd4, 1);
    issue(3'd2, 32'd1, 32'd35, 1);
    idle(1);
    check("b2b_third_valid", 64'(valid_o), 64'd1);
    check("b2b_third_data", 64'(data_o), 64'h8);
    idle(2);

    // MUL -3*7: ready low for 32 cycles, result on 33rd
    issue(3'd5, -32'sd3, 32'd7, 1);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk_i);
      valid_i = 1'b0;
      if (k == 1 || k == 32) begin
        check("mul_ready_low", 64'(ready_o), 64'd0);
        check("mul_busy_high", 64'(busy_o), 64'd1);
      end
    end
    @(negedge clk_i);
    check("mul_ready_back", 64'(ready_o), 64'd1);
    check("mul_valid", 64'(valid_o), 64'd1);
    check("mul_data", 64'(data_o), 64'hFFFF_FFEB);

    // MUL with a held ADD behind it
    issue(3'd5, 32'd1234, 32'd5678, 1);
    issue(3'd3, 32'd1, 32'd1, 1);
    check("held_add_mul_valid", 64'(valid_o), 64'd1);
    idle(1);
    check("held_add_valid", 64'(valid_o), 64'd1);
    check("held_add_data", 64'(data_o), 64'd2);
    idle(1);

    // wrap-around MUL
    issue(3'd5, 32'h10000, 32'h10000, 1);
    idle(34);
    check("wrap_zero", 64'(Zero_o), 64'd1);

    // flush mid-MUL: no result, data_o unchanged
    issue(3'd3, 32'd40, 32'd2, 1);
    idle(1);
    held = data_o;
    issue(3'd5, 32'd9, 32'd9, 0);
    idle(9);                       // now in cycle T+9
    @(negedge clk_i);              // cycle T+10
    check("flush_busy_before", 64'(busy_o), 64'd1);
    flush_i = 1'b1;
    @(negedge clk_i);              // cycle T+11
    flush_i = 1'b0;
    check("flush_ready", 64'(ready_o), 64'd1);
    idle(40);
    check("flush_data_kept", 64'(data_o), 64'(held));

    // flush in IDLE drops a presented op
    @(negedge clk_i);
    valid_i = 1'b1; flush_i = 1'b1; ALUCtrl_i = 3'd5; data1_i = 32'd3; data2_i = 32'd3;
    @(negedge clk_i);
    check("idle_flush_ready", 64'(ready_o), 64'd1);
    check("idle_flush_busy", 64'(busy_o), 64'd0);
    valid_i = 1'b0; flush_i = 1'b0;
    idle(2);

    // async reset mid-MUL
    issue(3'd5, 32'd77, 32'd3, 0);
    idle(5);
    rst_n_i = 1'b0;
    #1;
    check("mid_rst_data", 64'(data_o), 64'd0);
    check("mid_rst_zero", 64'(Zero_o), 64'd1);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_valid", 64'(valid_o), 64'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    check("post_rst_ready", 64'(ready_o), 64'd1);
    idle(40);

    // random stimulus
    for (int i = 0; i < 150; i++) begin
      logic [2:0] op;
      logic [W-1:0] a, b;
      op = 3'($urandom_range(0, 7));
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 3))
        0: b = W'($urandom_range(0, 40));
        1: a = '0;
        default: ;
      endcase
      issue(op, a, b, 1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(40);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
